// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between I-cache refills and D-cache refill/writeback.
// One transaction in flight; round-robin on simultaneous requests; sticky protocol-error flag.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ic_addr,
  input  logic              i_ic_read,
  output logic              o_ic_waitrequest,
  output logic [DATA_W-1:0] o_ic_readdata,
  output logic              o_ic_readdata_valid,
  input  logic [ADDR_W-1:0] i_dc_addr,
  input  logic              i_dc_read,
  input  logic              i_dc_write,
  input  logic [DATA_W-1:0] i_dc_writedata,
  input  logic [BE_W-1:0]   i_dc_byte_en,
  output logic              o_dc_waitrequest,
  output logic [DATA_W-1:0] o_dc_readdata,
  output logic              o_dc_readdata_valid,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_read,
  output logic              o_m_write,
  output logic [DATA_W-1:0] o_m_writedata,
  output logic [BE_W-1:0]   o_m_byte_en,
  input  logic              i_m_waitrequest,
  input  logic [DATA_W-1:0] i_m_readdata,
  input  logic              i_m_readdata_valid,
  output logic              o_err
);

  typedef enum logic [2:0] {IDLE, I_CMD, D_CMD, I_WAIT, D_WAIT} state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg;  // 0 = I side, 1 = D side
  logic [ADDR_W-1:0]   m_addr_reg;
  logic                m_read_reg;
  logic                m_write_reg;
  logic [DATA_W-1:0]   m_writedata_reg;
  logic [BE_W-1:0]     m_byte_en_reg;
  logic                err_reg;

  logic ic_req, dc_req, grant_i, grant_d;
  logic cmd_accept, in_wait, stray_valid;

  assign ic_req      = i_ic_read;
  assign dc_req      = i_dc_read | i_dc_write;
  assign cmd_accept  = ((state_reg == I_CMD) || (state_reg == D_CMD)) && !i_m_waitrequest;
  assign in_wait     = (state_reg == I_WAIT) || (state_reg == D_WAIT);
  assign stray_valid = i_m_readdata_valid && !in_wait;

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        // D wins a tie only if I was granted last
        if (dc_req && (!ic_req || !last_grant_reg)) begin
          grant_d    = 1'b1;
          state_next = D_CMD;
        end else if (ic_req) begin
          grant_i    = 1'b1;
          state_next = I_CMD;
        end
      end
      I_CMD:   if (!i_m_waitrequest) state_next = m_write_reg ? IDLE : I_WAIT;
      D_CMD:   if (!i_m_waitrequest) state_next = m_write_reg ? IDLE : D_WAIT;
      I_WAIT:  if (i_m_readdata_valid) state_next = IDLE;
      D_WAIT:  if (i_m_readdata_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b0;
      m_addr_reg      <= '0;
      m_read_reg      <= 1'b0;
      m_write_reg     <= 1'b0;
      m_writedata_reg <= '0;
      m_byte_en_reg   <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_i) begin
        m_addr_reg      <= i_ic_addr;
        m_read_reg      <= 1'b1;
        m_write_reg     <= 1'b0;
        m_writedata_reg <= '0;
        m_byte_en_reg   <= '1;
        last_grant_reg  <= 1'b0;
      end else if (grant_d) begin
        // read+write together is resolved as a writeback
        m_addr_reg      <= i_dc_addr;
        m_read_reg      <= !i_dc_write;
        m_write_reg     <= i_dc_write;
        m_writedata_reg <= i_dc_writedata;
        m_byte_en_reg   <= i_dc_write ? i_dc_byte_en : '1;
        last_grant_reg  <= 1'b1;
      end else if (cmd_accept) begin
        m_read_reg  <= 1'b0;
        m_write_reg <= 1'b0;
      end
      if (stray_valid || (grant_d && i_dc_read && i_dc_write))
        err_reg <= 1'b1;
    end
  end

  assign o_ic_waitrequest    = !((state_reg == I_CMD) && !i_m_waitrequest);
  assign o_dc_waitrequest    = !((state_reg == D_CMD) && !i_m_waitrequest);
  assign o_ic_readdata_valid = (state_reg == I_WAIT) && i_m_readdata_valid;
  assign o_dc_readdata_valid = (state_reg == D_WAIT) && i_m_readdata_valid;
  assign o_ic_readdata       = i_m_readdata;
  assign o_dc_readdata       = i_m_readdata;
  assign o_m_addr            = m_addr_reg;
  assign o_m_read            = m_read_reg;
  assign o_m_write           = m_write_reg;
  assign o_m_writedata       = m_writedata_reg;
  assign o_m_byte_en         = m_byte_en_reg;
  assign o_err               = err_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reads, stalled writeback, round-robin,
// read+write conflict, stray read data and mid-transaction reset.
module tb_cache_mem_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_ic_addr;
  logic          i_ic_read;
  logic          o_ic_waitrequest;
  logic [127:0]  o_ic_readdata;
  logic          o_ic_readdata_valid;
  logic [31:0]   i_dc_addr;
  logic          i_dc_read;
  logic          i_dc_write;
  logic [127:0]  i_dc_writedata;
  logic [15:0]   i_dc_byte_en;
  logic          o_dc_waitrequest;
  logic [127:0]  o_dc_readdata;
  logic          o_dc_readdata_valid;
  logic [31:0]   o_m_addr;
  logic          o_m_read;
  logic          o_m_write;
  logic [127:0]  o_m_writedata;
  logic [15:0]   o_m_byte_en;
  logic          i_m_waitrequest;
  logic [127:0]  i_m_readdata;
  logic          i_m_readdata_valid;
  logic          o_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(128), .BE_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_ic_addr(i_ic_addr), .i_ic_read(i_ic_read),
    .o_ic_waitrequest(o_ic_waitrequest), .o_ic_readdata(o_ic_readdata),
    .o_ic_readdata_valid(o_ic_readdata_valid),
    .i_dc_addr(i_dc_addr), .i_dc_read(i_dc_read), .i_dc_write(i_dc_write),
    .i_dc_writedata(i_dc_writedata), .i_dc_byte_en(i_dc_byte_en),
    .o_dc_waitrequest(o_dc_waitrequest), .o_dc_readdata(o_dc_readdata),
    .o_dc_readdata_valid(o_dc_readdata_valid),
    .o_m_addr(o_m_addr), .o_m_read(o_m_read), .o_m_write(o_m_write),
    .o_m_writedata(o_m_writedata), .o_m_byte_en(o_m_byte_en),
    .i_m_waitrequest(i_m_waitrequest), .i_m_readdata(i_m_readdata),
    .i_m_readdata_valid(i_m_readdata_valid), .o_err(o_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_read"}, o_m_read, 0);
    chk({tag, "_m_write"}, o_m_write, 0);
    chk({tag, "_m_addr"}, o_m_addr, 0);
    chk({tag, "_m_wdata"}, o_m_writedata, 0);
    chk({tag, "_m_be"}, o_m_byte_en, 0);
    chk({tag, "_ic_wr"}, o_ic_waitrequest, 1);
    chk({tag, "_dc_wr"}, o_dc_waitrequest, 1);
    chk({tag, "_ic_vld"}, o_ic_readdata_valid, 0);
    chk({tag, "_dc_vld"}, o_dc_readdata_valid, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  // Called in the cycle right after a read grant; returns in the following IDLE cycle.
  task automatic serve_read(input bit d_side, input logic [31:0] addr, input logic [127:0] data);
    #1;
    chk("rd_cmd_read", o_m_read, 1);
    chk("rd_cmd_addr", o_m_addr, addr);
    chk("rd_cmd_be", o_m_byte_en, 16'hFFFF);
    chk("rd_owner_waitreq", d_side ? o_dc_waitrequest : o_ic_waitrequest, 0);
    chk("rd_other_waitreq", d_side ? o_ic_waitrequest : o_dc_waitrequest, 1);
    cyc();
    if (d_side) i_dc_read = 1'b0; else i_ic_read = 1'b0;
    i_m_readdata       = data;
    i_m_readdata_valid = 1'b1;
    #1;
    chk("rd_read_cleared", o_m_read, 0);
    chk("rd_owner_valid", d_side ? o_dc_readdata_valid : o_ic_readdata_valid, 1);
    chk("rd_other_valid", d_side ? o_ic_readdata_valid : o_dc_readdata_valid, 0);
    chk("rd_owner_data", d_side ? o_dc_readdata : o_ic_readdata, data);
    cyc();
    i_m_readdata_valid = 1'b0;
    #1;
    chk("rd_done_valid", d_side ? o_dc_readdata_valid : o_ic_readdata_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_ic_addr = '0; i_ic_read = 1'b0;
    i_dc_addr = '0; i_dc_read = 1'b0; i_dc_write = 1'b0;
    i_dc_writedata = '0; i_dc_byte_en = '0;
    i_m_waitrequest = 1'b0; i_m_readdata = '0; i_m_readdata_valid = 1'b0;

    // reset state
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // single I read at 0x100
    i_ic_addr = 32'h100; i_ic_read = 1'b1;
    #1;
    chk("i_rd_not_yet", o_m_read, 0);
    cyc();
    serve_read(1'b0, 32'h100, {16{8'hA5}});
    chk("i_rd_dc_waitreq", o_dc_waitrequest, 1);
    chk("i_rd_err", o_err, 0);

    // D writeback with 3 stall cycles
    i_dc_addr = 32'h2000; i_dc_write = 1'b1;
    i_dc_writedata = {4{32'hDEADBEEF}}; i_dc_byte_en = 16'hFFFF;
    i_m_waitrequest = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wb_stall_write", o_m_write, 1);
      chk("wb_stall_addr", o_m_addr, 32'h2000);
      chk("wb_stall_wdata", o_m_writedata, {4{32'hDEADBEEF}});
      chk("wb_stall_be", o_m_byte_en, 16'hFFFF);
      chk("wb_stall_dc_waitreq", o_dc_waitrequest, 1);
      cyc();
    end
    i_m_waitrequest = 1'b0;
    #1;
    chk("wb_acc_write", o_m_write, 1);
    chk("wb_acc_dc_waitreq", o_dc_waitrequest, 0);
    chk("wb_acc_ic_waitreq", o_ic_waitrequest, 1);
    cyc();
    i_dc_write = 1'b0;
    i_ic_addr = 32'h180; i_ic_read = 1'b1;
    #1;
    chk("wb_idle_write", o_m_write, 0);
    chk("wb_idle_dc_waitreq", o_dc_waitrequest, 1);
    cyc();
    serve_read(1'b0, 32'h180, {8{16'h1234}});   // IDLE right after write: immediate grant

    // round-robin right after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_ic_addr = 32'h300; i_ic_read = 1'b1;
    i_dc_addr = 32'h400; i_dc_read = 1'b1;
    cyc();
    serve_read(1'b1, 32'h400, {16{8'h11}});
    cyc();
    serve_read(1'b0, 32'h300, {16{8'h22}});
    i_dc_addr = 32'h440; i_dc_read = 1'b1;
    cyc();
    serve_read(1'b1, 32'h440, {16{8'h33}});
    i_ic_addr = 32'h340; i_ic_read = 1'b1;
    i_dc_addr = 32'h480; i_dc_read = 1'b1;
    cyc();
    serve_read(1'b0, 32'h340, {16{8'h44}});
    cyc();
    serve_read(1'b1, 32'h480, {16{8'h55}});
    chk("rr_err", o_err, 0);

    // D read and write together: treated as write, sticky error
    i_dc_addr = 32'h500; i_dc_read = 1'b1; i_dc_write = 1'b1;
    i_dc_writedata = {2{64'h0F0F0F0F_F0F0F0F0}}; i_dc_byte_en = 16'h00FF;
    cyc();
    i_dc_read = 1'b0; i_dc_write = 1'b0;
    #1;
    chk("rw_write", o_m_write, 1);
    chk("rw_read", o_m_read, 0);
    chk("rw_be", o_m_byte_en, 16'h00FF);
    chk("rw_wdata", o_m_writedata, {2{64'h0F0F0F0F_F0F0F0F0}});
    chk("rw_dc_waitreq", o_dc_waitrequest, 0);
    chk("rw_err_set", o_err, 1);
    cyc(); cyc(); cyc();
    chk("rw_err_sticky", o_err, 1);
    chk("rw_idle_write", o_m_write, 0);

    // stray read data in IDLE
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("stray_err_cleared", o_err, 0);
    i_m_readdata = {16{8'h77}}; i_m_readdata_valid = 1'b1;
    #1;
    chk("stray_ic_valid", o_ic_readdata_valid, 0);
    chk("stray_dc_valid", o_dc_readdata_valid, 0);
    cyc();
    i_m_readdata_valid = 1'b0;
    #1;
    chk("stray_err_set", o_err, 1);

    // reset while in D_WAIT, then a normal I read
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_dc_addr = 32'h600; i_dc_read = 1'b1;
    cyc();
    #1;
    chk("rw_dcmd_waitreq", o_dc_waitrequest, 0);
    cyc();
    i_dc_read = 1'b0;
    rst = 1'b1;
    #1;
    chk("dwait_no_strobe", o_dc_readdata_valid, 0);
    cyc();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    i_ic_addr = 32'h700; i_ic_read = 1'b1;
    cyc();
    serve_read(1'b0, 32'h700, {16{8'h5A}});
    chk("midrst_err", o_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
